// File: rtl/gda_pkg.sv
// Shared types and helpers for the gracefully-degrading approximate adder pipeline.
// No timing of its own: state encodings, carry-window index helper, parameter legality check.
// GDA_ERR_RECOVERY_EN adds the FIX state used for single-cycle exact correction.
package gda_pkg;

`ifdef GDA_ERR_RECOVERY_EN
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        FIX   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1
    } state_t;
`endif

    // Lowest bit index of the carry-prediction window feeding block k.
    function automatic int win_lo(input int k, input int m, input int p);
        return (k * m > p) ? (k * m - p) : 0;
    endfunction

    // Legal geometry: whole number of blocks, at least two blocks, non-empty window.
    function automatic bit params_ok(input int n, input int m, input int p, input int cnt_w);
        return (m >= 1) && (n % m == 0) && (n >= 2 * m) && (p >= 1) && (cnt_w >= 1);
    endfunction

endpackage

// File: rtl/gda_adder_pipe_if.sv
// Operand/result handshake bundle for the GDA adder pipeline.
// No storage; pure wiring between producer/consumer and the adder.
// Valid/ready on both sides; master drives operands and result-ready, slave is the adder.
interface gda_adder_pipe_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         in_exact;
    logic         out_valid;
    logic         out_ready;
    logic [N:0]   out_res;
    logic         out_err;
    logic         out_fixed;

    modport master (
        output in_valid, in_a, in_b, in_exact, out_ready,
        input  in_ready, out_valid, out_res, out_err, out_fixed
    );

    modport slave (
        input  in_valid, in_a, in_b, in_exact, out_ready,
        output in_ready, out_valid, out_res, out_err, out_fixed
    );
endinterface

// File: rtl/gda_carry_pred.sv
// Per-block carry-in prediction from a P-bit window versus the true ripple carry.
// Purely combinational, zero latency.
// No handshake; evaluated on whatever operands are presented.
module gda_carry_pred
    import gda_pkg::*;
#(
    parameter int N = 16,
    parameter int M = 4,
    parameter int P = 4
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [N/M-1:0] cin_pred,
    output logic [N/M-1:0] cin_true,
    output logic           err
);
    localparam int NB = N / M;

    // Block 0 always sees a zero carry-in, both predicted and true.
    assign cin_pred[0] = 1'b0;
    assign cin_true[0] = 1'b0;

    for (genvar k = 1; k < NB; k++) begin : g_blk
        localparam int HI = k * M - 1;
        localparam int LO = win_lo(k, M, P);
        localparam int W  = k * M - LO;

        logic [W-1:0]   win_sum;
        logic [k*M-1:0] pre_sum;

        // Carry-out of an unsigned add shows up as the truncated sum wrapping below an operand.
        assign win_sum     = a[HI:LO] + b[HI:LO];
        assign pre_sum     = a[HI:0] + b[HI:0];
        assign cin_pred[k] = (win_sum < a[HI:LO]);
        assign cin_true[k] = (pre_sum < a[HI:0]);
    end

    // Any mispredicted block carry makes the approximate sum differ from the exact one.
    assign err = |(cin_pred ^ cin_true);

endmodule

// File: rtl/gda_adder_pipe.sv
// Pipelined GDA approximate adder with one-entry output buffer and saturating error counter.
// Latency 1 cycle; 2 cycles when GDA_ERR_RECOVERY_EN is defined and an exact result is requested on error.
// in_ready = EMPTY or (FULL and out_ready); outputs hold while out_ready is low; zero-bubble accept+drain.
module gda_adder_pipe
    import gda_pkg::*;
#(
    parameter int N     = 16,
    parameter int M     = 4,
    parameter int P     = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    gda_adder_pipe_if.slave  io,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int NB        = N / M;
    localparam int MW        = M + 1;
    localparam bit PARAMS_OK = params_ok(N, M, P, CNT_W);

    logic [NB-1:0]    cin_pred;
    logic [NB-1:0]    cin_true;
    logic             pred_err;
    logic [N:0]       approx_sum;
    logic [N:0]       exact_sum;

    state_t           state;
    logic             out_valid_q;
    logic [N:0]       res_q;
    logic             err_q;
    logic             fixed_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_ready;
    logic             accept;
`ifdef GDA_ERR_RECOVERY_EN
    logic [N:0]       exact_q;
`endif

    gda_carry_pred #(
        .N (N),
        .M (M),
        .P (P)
    ) u_carry_pred (
        .a        (io.in_a),
        .b        (io.in_b),
        .cin_pred (cin_pred),
        .cin_true (cin_true),
        .err      (pred_err)
    );

    // Independent M-bit block adders; only the top block keeps its carry-out.
    for (genvar k = 0; k < NB; k++) begin : g_sum
        localparam int LO = k * M;
        if (k == NB - 1) begin : g_top
            assign approx_sum[N:LO] = {1'b0, io.in_a[N-1:LO]} + {1'b0, io.in_b[N-1:LO]} + MW'(cin_pred[k]);
            assign exact_sum[N:LO]  = {1'b0, io.in_a[N-1:LO]} + {1'b0, io.in_b[N-1:LO]} + MW'(cin_true[k]);
        end else begin : g_low
            assign approx_sum[LO+M-1:LO] = io.in_a[LO+M-1:LO] + io.in_b[LO+M-1:LO] + M'(cin_pred[k]);
            assign exact_sum[LO+M-1:LO]  = io.in_a[LO+M-1:LO] + io.in_b[LO+M-1:LO] + M'(cin_true[k]);
        end
    end

    // Ready depends only on state and downstream ready, never on the operands.
    assign in_ready = (state == EMPTY) || ((state == FULL) && io.out_ready);
    assign accept   = io.in_valid && in_ready;

    assign io.in_ready  = in_ready;
    assign io.out_valid = out_valid_q;
    assign io.out_res   = res_q;
    assign io.out_err   = err_q;
    assign io.out_fixed = fixed_q;
    assign err_cnt      = cnt_q;

    // Output buffer FSM: capture on accept, drain on out_ready, optional one-cycle exact fix-up.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            err_q       <= 1'b0;
            fixed_q     <= 1'b0;
`ifdef GDA_ERR_RECOVERY_EN
            exact_q     <= '0;
`endif
        end else begin
            case (state)
                EMPTY, FULL: begin
                    if (accept) begin
                        res_q   <= approx_sum;
                        err_q   <= pred_err;
                        fixed_q <= 1'b0;
`ifdef GDA_ERR_RECOVERY_EN
                        exact_q <= exact_sum;
                        if (io.in_exact && pred_err) begin
                            state       <= FIX;
                            out_valid_q <= 1'b0;
                        end else begin
                            state       <= FULL;
                            out_valid_q <= 1'b1;
                        end
`else
                        state       <= FULL;
                        out_valid_q <= 1'b1;
`endif
                    end else if ((state == FULL) && io.out_ready) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
`ifdef GDA_ERR_RECOVERY_EN
                FIX: begin
                    res_q       <= exact_q;
                    fixed_q     <= 1'b1;
                    state       <= FULL;
                    out_valid_q <= 1'b1;
                end
`endif
                default: begin
                    state       <= EMPTY;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of accepted transactions whose approximation erred.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (accept && pred_err && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Simulation-only sanity: legal geometry, and the carry-mismatch flag matches a full-width compare.
    always @(posedge clk) begin
        if (rst) begin
            assert (PARAMS_OK);
        end else if (accept) begin
            assert ((approx_sum != exact_sum) == pred_err);
        end
    end

endmodule

// File: tb/tb_gda_adder_pipe.sv
// Self-checking bench for gda_adder_pipe (N=16, M=4, P=4, CNT_W=4) plus an exact P=12 instance.
// Directed vectors, streaming, stall, saturation, reset-mid-fix and randomized scoreboard checks.
// Honors GDA_ERR_RECOVERY_EN when the build defines it.
`timescale 1ns/1ps
module tb_gda_adder_pipe;
    localparam int N     = 16;
    localparam int M     = 4;
    localparam int P     = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

`ifdef GDA_ERR_RECOVERY_EN
    localparam bit RECOV = 1'b1;
`else
    localparam bit RECOV = 1'b0;
`endif

    localparam logic [N-1:0] DA [4]        = '{16'h1234, 16'h00FF, 16'h00FF, 16'hFFFF};
    localparam logic [N-1:0] DB [4]        = '{16'h4321, 16'h0001, 16'h0001, 16'h0001};
    localparam logic         DEX [4]       = '{1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic         DERR [4]      = '{1'b0, 1'b1, 1'b1, 1'b1};
    localparam logic [N:0]   DR_APPROX [4] = '{17'h05555, 17'h00000, 17'h00000, 17'h0FF00};
    localparam logic [N:0]   DR_RECOV [4]  = '{17'h05555, 17'h00000, 17'h00100, 17'h10000};

    typedef struct packed {
        logic [N:0] res;
        logic       err;
        logic       fixed;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] err_cnt_x;
    int               n_checks = 0;
    int               n_fail   = 0;
    int               exp_cnt  = 0;

    gda_adder_pipe_if #(.N(N)) bus ();
    gda_adder_pipe_if #(.N(N)) bus_x ();

    gda_adder_pipe #(.N(N), .M(M), .P(P), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .io      (bus.slave),
        .err_cnt (err_cnt)
    );

    gda_adder_pipe #(.N(N), .M(M), .P(12), .CNT_W(CNT_W)) dut_x (
        .clk     (clk),
        .rst     (rst),
        .io      (bus_x.slave),
        .err_cnt (err_cnt_x)
    );

    always #5 clk = ~clk;

    // Reference: each block adds its own operand bits plus a carry guessed from
    // a zero-carry-in add of the window just below it; lower blocks drop carry-out.
    function automatic logic [N:0] model_approx(input logic [N-1:0] a, input logic [N-1:0] b, input int p);
        int unsigned ai  = 32'(a);
        int unsigned bi  = 32'(b);
        int unsigned res = 0;
        for (int k = 0; k < N / M; k++) begin
            int          lo  = (k * M > p) ? (k * M - p) : 0;
            int          w   = k * M - lo;
            int unsigned cin = 0;
            int unsigned blk;
            if (k > 0) cin = (((ai >> lo) % (1 << w)) + ((bi >> lo) % (1 << w))) >> w;
            blk = ((ai >> (k * M)) % (1 << M)) + ((bi >> (k * M)) % (1 << M)) + cin;
            if (k < N / M - 1) blk = blk % (1 << M);
            res = res + (blk << (k * M));
        end
        return (N+1)'(res);
    endfunction

    function automatic logic [N:0] exact_add(input logic [N-1:0] a, input logic [N-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [N-1:0] a, input logic [N-1:0] b, input logic ex);
        bus.in_valid = v;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_exact = ex;
    endtask

    function automatic logic [N-1:0] rand_op();
        return N'($urandom_range(0, 65535));
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        bus.out_ready   = 1'b0;
        bus_x.in_valid  = 1'b0;
        bus_x.in_a      = '0;
        bus_x.in_b      = '0;
        bus_x.in_exact  = 1'b0;
        bus_x.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_checks++; if (bus.out_res !== '0) begin n_fail++; $display("FAIL reset_out_res got %h want 0", bus.out_res); end
        n_checks++; if (bus.out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err got %b want 0", bus.out_err); end
        n_checks++; if (bus.out_fixed !== 1'b0) begin n_fail++; $display("FAIL reset_out_fixed got %b want 0", bus.out_fixed); end
        n_checks++; if (err_cnt !== '0) begin n_fail++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        exp_cnt = 0;
    endtask

    task automatic test_directed();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [N:0] exp_res;
            logic       fx;
            int         lat;
            fx      = RECOV && DEX[i] && DERR[i];
            exp_res = RECOV ? DR_RECOV[i] : DR_APPROX[i];
            lat     = fx ? 2 : 1;
            drive(1'b1, DA[i], DB[i], DEX[i]);
            tick();
            drive(1'b0, '0, '0, 1'b0);
            if (DERR[i] && exp_cnt < CMAX) exp_cnt++;
            for (int c = 1; c <= lat; c++) begin
                n_checks++;
                if (bus.out_valid !== 1'(c == lat)) begin n_fail++; $display("FAIL dir%0d_valid_c%0d got %b want %b", i, c, bus.out_valid, (c == lat)); end
                if (c < lat) begin
                    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL dir%0d_fix_in_ready got %b want 0", i, bus.in_ready); end
                end else begin
                    n_checks++; if (bus.out_res !== exp_res) begin n_fail++; $display("FAIL dir%0d_res got %h want %h", i, bus.out_res, exp_res); end
                    n_checks++; if (bus.out_err !== DERR[i]) begin n_fail++; $display("FAIL dir%0d_err got %b want %b", i, bus.out_err, DERR[i]); end
                    n_checks++; if (bus.out_fixed !== fx) begin n_fail++; $display("FAIL dir%0d_fixed got %b want %b", i, bus.out_fixed, fx); end
                    n_checks++; if (err_cnt !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL dir%0d_err_cnt got %0d want %0d", i, err_cnt, exp_cnt); end
                end
                tick();
            end
            n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_drained got %b want 0", i, bus.out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] a, b;
        logic [N:0]   last_res, exp_res;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a = rand_op();
            b = rand_op();
            drive(1'b1, a, b, 1'b0);
            #1;
            n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b%0d_in_ready got %b want 1", i, bus.in_ready); end
            tick();
            exp_res = model_approx(a, b, P);
            if (exp_res != exact_add(a, b) && exp_cnt < CMAX) exp_cnt++;
            n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b%0d_valid got %b want 1", i, bus.out_valid); end
            n_checks++; if (bus.out_res !== exp_res) begin n_fail++; $display("FAIL b2b%0d_res got %h want %h", i, bus.out_res, exp_res); end
            n_checks++; if (bus.out_err !== 1'(exp_res != exact_add(a, b))) begin n_fail++; $display("FAIL b2b%0d_err got %b want %b", i, bus.out_err, (exp_res != exact_add(a, b))); end
        end
        last_res = model_approx(a, b, P);
        a = rand_op();
        b = rand_op();
        drive(1'b1, a, b, 1'b0);
        bus.out_ready = 1'b0;
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got %b want 0", bus.in_ready); end
        for (int s = 0; s < 3; s++) begin
            tick();
            n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall%0d_valid got %b want 1", s, bus.out_valid); end
            n_checks++; if (bus.out_res !== last_res) begin n_fail++; $display("FAIL stall%0d_res got %h want %h", s, bus.out_res, last_res); end
            n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall%0d_in_ready got %b want 0", s, bus.in_ready); end
        end
        bus.out_ready = 1'b1;
        tick();
        exp_res = model_approx(a, b, P);
        if (exp_res != exact_add(a, b) && exp_cnt < CMAX) exp_cnt++;
        n_checks++; if (bus.out_res !== exp_res) begin n_fail++; $display("FAIL post_stall_res got %h want %h", bus.out_res, exp_res); end
        drive(1'b0, '0, '0, 1'b0);
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL post_stall_drain got %b want 0", bus.out_valid); end
        n_checks++; if (err_cnt !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL b2b_err_cnt got %0d want %0d", err_cnt, exp_cnt); end
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            drive(1'b1, 16'h00FF, 16'h0001, 1'b0);
            tick();
            exp_cnt = (i < CMAX) ? i : CMAX;
            n_checks++; if (err_cnt !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL sat%0d_err_cnt got %0d want %0d", i, err_cnt, exp_cnt); end
        end
        drive(1'b0, '0, '0, 1'b0);
        tick();
        drive(1'b1, 16'h00FF, 16'h0001, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        rst = 1'b1;
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_fix_valid got %b want 0", bus.out_valid); end
        n_checks++; if (err_cnt !== '0) begin n_fail++; $display("FAIL rst_fix_err_cnt got %0d want 0", err_cnt); end
        rst = 1'b0;
        exp_cnt = 0;
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_fix_dropped got %b want 0", bus.out_valid); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_fix_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_random_model();
        exp_t         q[$];
        exp_t         e;
        logic [N-1:0] a, b;
        logic [N:0]   ap;
        for (int cyc = 0; cyc < 610; cyc++) begin
            tick();
            a = rand_op();
            b = ($urandom_range(0, 2) == 0) ? N'(~a + N'($urandom_range(0, 3))) : rand_op();
            if (cyc < 600) drive(1'($urandom_range(0, 9) < 7), a, b, 1'($urandom_range(0, 1)));
            else drive(1'b0, '0, '0, 1'b0);
            bus.out_ready = (cyc < 600) ? 1'($urandom_range(0, 9) < 7) : 1'b1;
            #1;
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_unexpected_out got %h want none", bus.out_res);
                end else begin
                    e = q.pop_front();
                    if ({bus.out_res, bus.out_err, bus.out_fixed} !== e) begin
                        n_fail++; $display("FAIL rnd_out got res=%h err=%b fix=%b want res=%h err=%b fix=%b",
                                           bus.out_res, bus.out_err, bus.out_fixed, e.res, e.err, e.fixed);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                ap      = model_approx(bus.in_a, bus.in_b, P);
                e.err   = (ap != exact_add(bus.in_a, bus.in_b));
                e.fixed = RECOV && bus.in_exact && e.err;
                e.res   = e.fixed ? exact_add(bus.in_a, bus.in_b) : ap;
                q.push_back(e);
                if (e.err && exp_cnt < CMAX) exp_cnt++;
            end
        end
        n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL rnd_leftover got %0d want 0", q.size()); end
        n_checks++; if (err_cnt !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL rnd_err_cnt got %0d want %0d", err_cnt, exp_cnt); end
    endtask

    task automatic test_exact_config();
        logic [N-1:0] a, b;
        bus_x.out_ready = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            a = rand_op();
            b = ($urandom_range(0, 1) == 0) ? N'(~a + N'($urandom_range(0, 2))) : rand_op();
            bus_x.in_valid = 1'b1;
            bus_x.in_a     = a;
            bus_x.in_b     = b;
            tick();
            n_checks++;
            if (bus_x.out_valid !== 1'b1 || bus_x.out_res !== exact_add(a, b) || bus_x.out_err !== 1'b0) begin
                n_fail++; $display("FAIL exact%0d got v=%b res=%h err=%b want v=1 res=%h err=0",
                                   i, bus_x.out_valid, bus_x.out_res, bus_x.out_err, exact_add(a, b));
            end
        end
        bus_x.in_valid = 1'b0;
        tick();
        n_checks++; if (err_cnt_x !== '0) begin n_fail++; $display("FAIL exact_err_cnt got %0d want 0", err_cnt_x); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_saturation();
        test_random_model();
        test_exact_config();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
